// File: rtl/io_pmp_check_arbiter_if.sv
// Address-check bundle between the AXI AW/AR slave channels, the shared pmp checker and the decision consumers.
// Deny-counter signals exist only when IO_PMP_CHECK_ARB_STATS_EN is defined.
interface io_pmp_check_arbiter_if #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STAT_WIDTH = 32
);
  logic                  cfg_busy_i;

  logic                  aw_valid_i;
  logic                  aw_ready_o;
  logic [PLEN-1:0]       aw_addr_i;
  logic [ID_WIDTH-1:0]   aw_id_i;

  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [PLEN-1:0]       ar_addr_i;
  logic [ID_WIDTH-1:0]   ar_id_i;

  logic [PLEN-1:0]       pmp_addr_o;
  logic [2:0]            pmp_access_type_o;
  logic                  pmp_allow_i;

  logic                  aw_dec_valid_o;
  logic                  aw_dec_ready_i;
  logic                  aw_dec_allow_o;
  logic [ID_WIDTH-1:0]   aw_dec_id_o;

  logic                  ar_dec_valid_o;
  logic                  ar_dec_ready_i;
  logic                  ar_dec_allow_o;
  logic [ID_WIDTH-1:0]   ar_dec_id_o;

`ifdef IO_PMP_CHECK_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] aw_deny_cnt_o;
  logic [STAT_WIDTH-1:0] ar_deny_cnt_o;
`endif

  // Arbiter side.
  modport slave (
    input  cfg_busy_i,
    input  aw_valid_i, aw_addr_i, aw_id_i,
    output aw_ready_o,
    input  ar_valid_i, ar_addr_i, ar_id_i,
    output ar_ready_o,
    output pmp_addr_o, pmp_access_type_o,
    input  pmp_allow_i,
    output aw_dec_valid_o, aw_dec_allow_o, aw_dec_id_o,
    input  aw_dec_ready_i,
    output ar_dec_valid_o, ar_dec_allow_o, ar_dec_id_o,
    input  ar_dec_ready_i
`ifdef IO_PMP_CHECK_ARB_STATS_EN
    ,
    output aw_deny_cnt_o, ar_deny_cnt_o
`endif
  );

  // Requester / pmp / decision-consumer side.
  modport master (
    output cfg_busy_i,
    output aw_valid_i, aw_addr_i, aw_id_i,
    input  aw_ready_o,
    output ar_valid_i, ar_addr_i, ar_id_i,
    input  ar_ready_o,
    input  pmp_addr_o, pmp_access_type_o,
    output pmp_allow_i,
    input  aw_dec_valid_o, aw_dec_allow_o, aw_dec_id_o,
    output aw_dec_ready_i,
    input  ar_dec_valid_o, ar_dec_allow_o, ar_dec_id_o,
    output ar_dec_ready_i
`ifdef IO_PMP_CHECK_ARB_STATS_EN
    ,
    input  aw_deny_cnt_o, ar_deny_cnt_o
`endif
  );
endinterface

// File: rtl/io_pmp_check_arbiter.sv
// Round-robin sharing of one pmp checker between AXI AW and AR address streams; one-entry decision slot per channel.
// Optional saturating deny counters under IO_PMP_CHECK_ARB_STATS_EN.
module io_pmp_check_arbiter #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  io_pmp_check_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOOKUP} state_e;
  typedef enum logic {CH_AW, CH_AR} chan_e;

  localparam logic [2:0] ACC_NONE  = 3'b000;
  localparam logic [2:0] ACC_READ  = 3'b001;
  localparam logic [2:0] ACC_WRITE = 3'b010;

  state_e              state_q, state_d;
  chan_e               last_grant_q;
  chan_e               cur_chan_q;
  logic [PLEN-1:0]     addr_q;
  logic [ID_WIDTH-1:0] id_q;

  logic                aw_slot_valid_q, aw_slot_allow_q;
  logic [ID_WIDTH-1:0] aw_slot_id_q;
  logic                ar_slot_valid_q, ar_slot_allow_q;
  logic [ID_WIDTH-1:0] ar_slot_id_q;

  logic aw_elig, ar_elig;
  logic aw_grant, ar_grant;
  logic lookup_done;

  // Reset gates eligibility so readies drop the moment rst_ni falls.
  assign aw_elig = rst_ni & bus.aw_valid_i & ~aw_slot_valid_q & ~bus.cfg_busy_i;
  assign ar_elig = rst_ni & bus.ar_valid_i & ~ar_slot_valid_q & ~bus.cfg_busy_i;

  always_comb begin
    state_d  = state_q;
    aw_grant = 1'b0;
    ar_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_elig && ar_elig) begin
          aw_grant = (last_grant_q == CH_AR);
          ar_grant = (last_grant_q == CH_AW);
        end else begin
          aw_grant = aw_elig;
          ar_grant = ar_elig;
        end
        if (aw_grant || ar_grant) state_d = LOOKUP;
      end
      LOOKUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lookup_done = (state_q == LOOKUP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= CH_AR;
      cur_chan_q   <= CH_AW;
      addr_q       <= '0;
      id_q         <= '0;
    end else if (aw_grant) begin
      last_grant_q <= CH_AW;
      cur_chan_q   <= CH_AW;
      addr_q       <= bus.aw_addr_i;
      id_q         <= bus.aw_id_i;
    end else if (ar_grant) begin
      last_grant_q <= CH_AR;
      cur_chan_q   <= CH_AR;
      addr_q       <= bus.ar_addr_i;
      id_q         <= bus.ar_id_i;
    end
  end

  // A channel is only granted with its slot empty, so fill and drain never coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_slot_valid_q <= 1'b0;
      aw_slot_allow_q <= 1'b0;
      aw_slot_id_q    <= '0;
    end else if (lookup_done && cur_chan_q == CH_AW) begin
      aw_slot_valid_q <= 1'b1;
      aw_slot_allow_q <= bus.pmp_allow_i;
      aw_slot_id_q    <= id_q;
    end else if (aw_slot_valid_q && bus.aw_dec_ready_i) begin
      aw_slot_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_slot_valid_q <= 1'b0;
      ar_slot_allow_q <= 1'b0;
      ar_slot_id_q    <= '0;
    end else if (lookup_done && cur_chan_q == CH_AR) begin
      ar_slot_valid_q <= 1'b1;
      ar_slot_allow_q <= bus.pmp_allow_i;
      ar_slot_id_q    <= id_q;
    end else if (ar_slot_valid_q && bus.ar_dec_ready_i) begin
      ar_slot_valid_q <= 1'b0;
    end
  end

  assign bus.aw_ready_o        = aw_grant;
  assign bus.ar_ready_o        = ar_grant;
  assign bus.pmp_addr_o        = addr_q;
  assign bus.pmp_access_type_o = !lookup_done          ? ACC_NONE :
                                 (cur_chan_q == CH_AW) ? ACC_WRITE : ACC_READ;

  assign bus.aw_dec_valid_o = aw_slot_valid_q;
  assign bus.aw_dec_allow_o = aw_slot_allow_q;
  assign bus.aw_dec_id_o    = aw_slot_id_q;
  assign bus.ar_dec_valid_o = ar_slot_valid_q;
  assign bus.ar_dec_allow_o = ar_slot_allow_q;
  assign bus.ar_dec_id_o    = ar_slot_id_q;

`ifdef IO_PMP_CHECK_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] aw_deny_cnt_q, ar_deny_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_deny_cnt_q <= '0;
      ar_deny_cnt_q <= '0;
    end else if (lookup_done && !bus.pmp_allow_i) begin
      if (cur_chan_q == CH_AW && aw_deny_cnt_q != '1) aw_deny_cnt_q <= aw_deny_cnt_q + 1'b1;
      if (cur_chan_q == CH_AR && ar_deny_cnt_q != '1) ar_deny_cnt_q <= ar_deny_cnt_q + 1'b1;
    end
  end

  assign bus.aw_deny_cnt_o = aw_deny_cnt_q;
  assign bus.ar_deny_cnt_o = ar_deny_cnt_q;
`endif
endmodule

// File: tb/tb_io_pmp_check_arbiter.sv
// Directed bench for io_pmp_check_arbiter: inputs driven 1 time unit after posedge, outputs sampled 2 units after.
// Deny-counter checks are compiled in when IO_PMP_CHECK_ARB_STATS_EN is defined.
module tb_io_pmp_check_arbiter;
  localparam int unsigned PLEN     = 56;
  localparam int unsigned ID_WIDTH = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  io_pmp_check_arbiter_if #(.PLEN(PLEN), .ID_WIDTH(ID_WIDTH), .STAT_WIDTH(32)) bus ();

  io_pmp_check_arbiter #(.PLEN(PLEN), .ID_WIDTH(ID_WIDTH), .STAT_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.cfg_busy_i     = 1'b0;
    bus.aw_valid_i     = 1'b0;
    bus.aw_addr_i      = '0;
    bus.aw_id_i        = '0;
    bus.ar_valid_i     = 1'b1;
    bus.ar_addr_i      = 56'h4000;
    bus.ar_id_i        = 8'h7e;
    bus.pmp_allow_i    = 1'b0;
    bus.aw_dec_ready_i = 1'b0;
    bus.ar_dec_ready_i = 1'b0;

    // Reset state, with a read request already pending.
    step(); step(); #1;
    check("rst_aw_ready", bus.aw_ready_o, 0);
    check("rst_ar_ready", bus.ar_ready_o, 0);
    check("rst_aw_dec_valid", bus.aw_dec_valid_o, 0);
    check("rst_ar_dec_valid", bus.ar_dec_valid_o, 0);
    check("rst_aw_dec_allow", bus.aw_dec_allow_o, 0);
    check("rst_ar_dec_id", bus.ar_dec_id_o, 0);
    check("rst_pmp_addr", bus.pmp_addr_o, 0);
    check("rst_access", bus.pmp_access_type_o, 3'b000);

    // Single AW lookup: ready at N, WRITE at N+1, decision at N+2.
    step();
    rst_n = 1'b1;
    bus.ar_valid_i = 1'b0;
    bus.aw_valid_i = 1'b1;
    bus.aw_addr_i  = 56'h8000_1000;
    bus.aw_id_i    = 8'h05;
    #1;
    check("t1_aw_ready_N", bus.aw_ready_o, 1);
    check("t1_ar_ready_N", bus.ar_ready_o, 0);
    check("t1_access_N", bus.pmp_access_type_o, 3'b000);
    step();
    bus.aw_valid_i  = 1'b0;
    bus.pmp_allow_i = 1'b1;
    #1;
    check("t1_access_N1", bus.pmp_access_type_o, 3'b010);
    check("t1_pmp_addr_N1", bus.pmp_addr_o, 64'h8000_1000);
    check("t1_aw_ready_N1", bus.aw_ready_o, 0);
    step(); #1;
    check("t1_dec_valid_N2", bus.aw_dec_valid_o, 1);
    check("t1_dec_allow_N2", bus.aw_dec_allow_o, 1);
    check("t1_dec_id_N2", bus.aw_dec_id_o, 8'h05);
    check("t1_ar_dec_valid_N2", bus.ar_dec_valid_o, 0);
    check("t1_access_N2", bus.pmp_access_type_o, 3'b000);
    check("t1_pmp_addr_hold", bus.pmp_addr_o, 64'h8000_1000);
    step(); #1;
    check("t1_dec_hold_valid", bus.aw_dec_valid_o, 1);
    check("t1_dec_hold_id", bus.aw_dec_id_o, 8'h05);
    bus.aw_dec_ready_i = 1'b1;
    step(); #1;
    check("t1_dec_cleared", bus.aw_dec_valid_o, 0);

    // Both streams saturated; AW won last, so AR leads: AR,AW,AR,AW every 2 cycles.
    bus.aw_valid_i     = 1'b1;
    bus.aw_id_i        = 8'h11;
    bus.aw_addr_i      = 56'h1000;
    bus.ar_valid_i     = 1'b1;
    bus.ar_id_i        = 8'h22;
    bus.ar_addr_i      = 56'h2000;
    bus.ar_dec_ready_i = 1'b1;
    bus.pmp_allow_i    = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin step(); #1; end
      check($sformatf("t2_ar_ready_k%0d", k), bus.ar_ready_o, (k % 4 == 0));
      check($sformatf("t2_aw_ready_k%0d", k), bus.aw_ready_o, (k % 4 == 2));
      check($sformatf("t2_access_k%0d", k), bus.pmp_access_type_o,
            (k % 4 == 1) ? 3'b001 : (k % 4 == 3) ? 3'b010 : 3'b000);
      if (k == 2) check("t2_ar_dec_id", bus.ar_dec_id_o, 8'h22);
      if (k == 4) check("t2_aw_dec_id", bus.aw_dec_id_o, 8'h11);
    end
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
    step(); step(); step();

    // AR decision held (denied) while both keep requesting; AW served alone once its slot drains.
    bus.ar_dec_ready_i = 1'b0;
    bus.aw_valid_i     = 1'b1;
    bus.aw_id_i        = 8'h12;
    bus.ar_valid_i     = 1'b1;
    bus.ar_id_i        = 8'h33;
    bus.ar_addr_i      = 56'h3000;
    for (int j = 0; j < 10; j++) begin
      if (j != 0) step();
      bus.pmp_allow_i = (j == 1) ? 1'b0 : 1'b1;
      if (j == 3) bus.ar_id_i = 8'h44;
      #1;
      check($sformatf("t3_ar_ready_j%0d", j), bus.ar_ready_o, (j == 0));
      check($sformatf("t3_aw_ready_j%0d", j), bus.aw_ready_o, (j == 2 || j == 5 || j == 8));
      if (j >= 2) begin
        check($sformatf("t3_ar_hold_valid_j%0d", j), bus.ar_dec_valid_o, 1);
        check($sformatf("t3_ar_hold_id_j%0d", j), bus.ar_dec_id_o, 8'h33);
        check($sformatf("t3_ar_hold_allow_j%0d", j), bus.ar_dec_allow_o, 0);
      end
      if (j == 4 || j == 7) begin
        check($sformatf("t3_aw_dec_valid_j%0d", j), bus.aw_dec_valid_o, 1);
        check($sformatf("t3_aw_dec_id_j%0d", j), bus.aw_dec_id_o, 8'h12);
      end
    end
    bus.aw_valid_i     = 1'b0;
    bus.ar_valid_i     = 1'b0;
    bus.ar_dec_ready_i = 1'b1;
    bus.pmp_allow_i    = 1'b1;
    step(); step(); step();

    // cfg_busy raised during an AR lookup: decision still produced, grants frozen until busy drops.
    bus.ar_valid_i = 1'b1;
    bus.ar_id_i    = 8'h55;
    bus.ar_addr_i  = 56'h2000;
    #1;
    check("t4_ar_ready_c0", bus.ar_ready_o, 1);
    step();
    bus.cfg_busy_i = 1'b1;
    #1;
    check("t4_access_c1", bus.pmp_access_type_o, 3'b001);
    check("t4_pmp_addr_c1", bus.pmp_addr_o, 64'h2000);
    check("t4_ar_ready_c1", bus.ar_ready_o, 0);
    step();
    bus.aw_valid_i = 1'b1;
    bus.aw_id_i    = 8'h66;
    #1;
    check("t4_ar_dec_valid_c2", bus.ar_dec_valid_o, 1);
    check("t4_ar_dec_id_c2", bus.ar_dec_id_o, 8'h55);
    check("t4_ar_dec_allow_c2", bus.ar_dec_allow_o, 1);
    check("t4_ar_ready_c2", bus.ar_ready_o, 0);
    check("t4_aw_ready_c2", bus.aw_ready_o, 0);
    step(); #1;
    check("t4_ar_ready_busy", bus.ar_ready_o, 0);
    check("t4_aw_ready_busy", bus.aw_ready_o, 0);
    check("t4_ar_dec_cleared", bus.ar_dec_valid_o, 0);
    step();
    bus.cfg_busy_i = 1'b0;
    #1;
    check("t4_aw_ready_resume", bus.aw_ready_o, 1);
    check("t4_ar_ready_resume", bus.ar_ready_o, 0);
    step();
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
    #1;
    check("t4_access_aw", bus.pmp_access_type_o, 3'b010);
    step(); #1;
    check("t4_aw_dec_id", bus.aw_dec_id_o, 8'h66);
    step();

    // Three denied reads back to back.
    bus.ar_valid_i  = 1'b1;
    bus.ar_id_i     = 8'h77;
    bus.pmp_allow_i = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i != 0) begin step(); #1; end
      check($sformatf("t5_ar_ready_i%0d", i), bus.ar_ready_o, (i % 3 == 0));
      if (i % 3 == 2) begin
        check($sformatf("t5_ar_dec_valid_i%0d", i), bus.ar_dec_valid_o, 1);
        check($sformatf("t5_ar_dec_allow_i%0d", i), bus.ar_dec_allow_o, 0);
      end
    end
    bus.ar_valid_i  = 1'b0;
    bus.pmp_allow_i = 1'b1;
`ifdef IO_PMP_CHECK_ARB_STATS_EN
    // One earlier AR denial from the held-decision phase plus these three.
    check("t5_ar_deny_cnt", bus.ar_deny_cnt_o, 4);
    check("t5_aw_deny_cnt", bus.aw_deny_cnt_o, 0);
`endif

    // Reset during an AW lookup with an AR decision still pending.
    step();
    bus.ar_dec_ready_i = 1'b0;
    bus.ar_valid_i     = 1'b1;
    #1;
    check("t6_ar_ready_s0", bus.ar_ready_o, 1);
    step();
    bus.ar_valid_i = 1'b0;
    step();
    bus.aw_valid_i = 1'b1;
    #1;
    check("t6_ar_dec_pending", bus.ar_dec_valid_o, 1);
    check("t6_aw_ready_s2", bus.aw_ready_o, 1);
    step(); #1;
    check("t6_access_lookup", bus.pmp_access_type_o, 3'b010);
    rst_n = 1'b0;
    bus.ar_valid_i = 1'b1;
    #1;
    check("t6_rst_aw_ready", bus.aw_ready_o, 0);
    check("t6_rst_ar_ready", bus.ar_ready_o, 0);
    check("t6_rst_ar_dec_valid", bus.ar_dec_valid_o, 0);
    check("t6_rst_aw_dec_valid", bus.aw_dec_valid_o, 0);
    check("t6_rst_access", bus.pmp_access_type_o, 3'b000);
    check("t6_rst_pmp_addr", bus.pmp_addr_o, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("t6_post_aw_ready", bus.aw_ready_o, 1);
    check("t6_post_ar_ready", bus.ar_ready_o, 0);
    check("t6_post_ar_dec_valid", bus.ar_dec_valid_o, 0);
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_pmp_check_arbiter.md
Name: io_pmp_check_arbiter

Overview:
Shares one combinational `pmp` checker between the AXI AW (write) and AR (read) address streams of the IO-PMP.
- Round-robin arbitration between the two streams.
- Sequences each lookup: accept, then check, then decision.
- Returns a per-channel allow/deny decision tagged with the transaction ID.
- Sits between the slave-port address channels and the IO-PMP's forwarding/error logic, so that a single `pmp` instance checks both directions.

Parameters:
- PLEN, 56, physical address width presented to `pmp` (rv64: 56, rv32: 34)
- ID_WIDTH, 8, AXI ID width
- STAT_WIDTH, 32, width of denial counters (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_busy_i  in  1  PMP configuration being rewritten; blocks new grants
- aw_valid_i  in  1  write-address check request
- aw_ready_o  out  1  write-address request accepted
- aw_addr_i  in  PLEN  write address
- aw_id_i  in  ID_WIDTH  write ID
- ar_valid_i  in  1  read-address check request
- ar_ready_o  out  1  read-address request accepted
- ar_addr_i  in  PLEN  read address
- ar_id_i  in  ID_WIDTH  read ID
- pmp_addr_o  out  PLEN  address to `pmp.addr_i`
- pmp_access_type_o  out  3  to `pmp.access_type_i`: 3'b001 = READ, 3'b010 = WRITE, 3'b000 = NONE
- pmp_allow_i  in  1  `pmp.allow_o`
- aw_dec_valid_o  out  1  write decision valid
- aw_dec_ready_i  in  1  write decision consumed
- aw_dec_allow_o  out  1  1 = permitted, 0 = deny (SLVERR path)
- aw_dec_id_o  out  ID_WIDTH  ID of decided write
- ar_dec_valid_o / ar_dec_ready_i / ar_dec_allow_o / ar_dec_id_o: same as the AW decision ports, for reads
- aw_deny_cnt_o, ar_deny_cnt_o  out  STAT_WIDTH  denial counters (optional feature only)

Behaviour:
- FSM states IDLE and LOOKUP. Reset state is IDLE.
- Reset values:
  - All `*_ready_o` = 0, all `*_dec_valid_o` = 0, all `*_dec_allow_o` = 0, all `*_dec_id_o` = 0.
  - `pmp_addr_o` = 0, `pmp_access_type_o` = NONE.
  - Round-robin pointer `last_grant` = AR, so AW wins the first tie.
- Per channel there is a one-entry result slot {valid, allow, id}. The `*_dec_*` outputs are driven directly from this slot.
- Grant eligibility, evaluated in IDLE only: channel X is eligible iff `X_valid_i`, X's slot is empty, and `cfg_busy_i` = 0.
  - Both eligible: grant the channel that is not `last_grant`.
  - Exactly one eligible: grant it.
- `X_ready_o` = 1 combinationally only for the granted channel while in IDLE. At most one ready is high per cycle. Ready may depend on valid.
- On acceptance (valid & ready) at cycle N:
  - Latch addr, id, and the channel.
  - Update `last_grant`.
  - Move to LOOKUP.
- In LOOKUP (cycle N+1):
  - `pmp_addr_o` = latched addr; `pmp_access_type_o` = WRITE for AW, READ for AR.
  - At the clock edge, write {1, `pmp_allow_i`, id} into the channel's slot and return to IDLE.
- Outside LOOKUP, `pmp_access_type_o` = NONE and `pmp_addr_o` holds its last value.
- Latency: decision valid at N+2. Throughput: one check per 2 cycles.
- A slot clears on `X_dec_valid_o & X_dec_ready_i`. A slot cleared in cycle M makes the channel eligible in cycle M+1, not in M.
- `*_dec_*` outputs are stable while valid and not ready (AXI-style hold).
- `cfg_busy_i` rising while in LOOKUP: the in-flight lookup completes using the current `pmp_allow_i`. No new grant is made until `cfg_busy_i` = 0.
- A requester holding valid with its slot full is stalled. The other channel continues to be served (no head-of-line blocking).
- Reset asserted mid-LOOKUP: the FSM returns to IDLE, slots clear, and the in-flight request is dropped. The requester has already seen its handshake, so the upstream is reset together with this block.

Optional Feature:
Macro: IO_PMP_CHECK_ARB_STATS_EN
- Defined:
  - `aw_deny_cnt_o` and `ar_deny_cnt_o` exist.
  - Each increments by 1 when a LOOKUP for its channel completes with `pmp_allow_i` = 0.
  - Each saturates at all-ones and resets to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- AW only, addr 0x8000_1000, id 0x05, `pmp_allow_i` = 1 in LOOKUP -> `aw_ready_o` = 1 at N; `pmp_access_type_o` = 3'b010 at N+1; `aw_dec_valid_o` = 1, allow = 1, id = 0x05 at N+2.
- AW and AR valid every cycle, both dec_ready tied 1 -> grants alternate AW, AR, AW, AR, one every 2 cycles. Never both readies in the same cycle.
- AR decision held with `ar_dec_ready_i` = 0; AR and AW keep requesting -> `ar_ready_o` stays 0. AW keeps being served every 2 cycles. AR outputs stay stable until ready.
- `cfg_busy_i` raised on the LOOKUP cycle of an AR request -> that AR decision is still produced. No ready is asserted while busy. Granting resumes the cycle after busy falls.
- `pmp_allow_i` = 0 for 3 reads, with stats enabled -> `ar_dec_allow_o` = 0 three times; `ar_deny_cnt_o` = 3; `aw_deny_cnt_o` = 0. Preload a counter to all-ones -> it stays all-ones.
- Assert `rst_ni` = 0 during LOOKUP -> all valids and readies are 0 immediately. After release, the first tie is granted to AW.
